// File: rtl/keccak_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keccak_pkg                                                                 |
// | Shared constants, FSM states and bit-index helpers for the chi sequencer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package keccak_pkg;

  localparam int SLICE_W = 25;
  localparam int ROW_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Pairwise DOM cross terms: one fresh bit per share pair.
  function automatic int rand_w(input int shares);
    return (shares * shares - shares) / 2;
  endfunction

  function automatic int slice_idx(input int s, input int y, input int x);
    return s * SLICE_W + y * ROW_W + x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_row_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keccak_row_mux                                                             |
// | Extracts row y of every share from a shared plane; all-zero when disabled. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module keccak_row_mux
  import keccak_pkg::*;
#(
  parameter int SHARES = 2
) (
  input  logic [SHARES*SLICE_W-1:0] SlicexDI,
  input  logic [2:0]                RowxDI,
  input  logic                      EnxSI,
  output logic [SHARES*ROW_W-1:0]   RowxDO
);

  // Padded to eight entries so a 3-bit row index can never select outside the table.
  logic [7:0][SHARES*ROW_W-1:0] w_rows;

  for (genvar gy = 0; gy < 8; gy++) begin : g_row
    for (genvar gs = 0; gs < SHARES; gs++) begin : g_share
      for (genvar gx = 0; gx < ROW_W; gx++) begin : g_lane
        if (gy < ROW_W) begin : g_used
          assign w_rows[gy][gs*ROW_W+gx] = SlicexDI[slice_idx(gs, gy, gx)];
        end else begin : g_pad
          assign w_rows[gy][gs*ROW_W+gx] = 1'b0;
        end
      end
    end
  end

  assign RowxDO = EnxSI ? w_rows[RowxDI] : '0;

endmodule
`default_nettype wire

// File: rtl/keccak_chi_row_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keccak_chi_row_sequencer                                                   |
// | Feeds a shared 5x5 plane row by row into a masked chi S-box and collects   |
// | the result plane. KECCAK_ROW_SEQ_IOTA_EN adds the iota round-constant bit. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module keccak_chi_row_sequencer
  import keccak_pkg::*;
#(
  parameter int SHARES   = 2,
  parameter int SBOX_LAT = 1,
  parameter int RAND_W   = rand_w(SHARES)
) (
  input  logic                      ClkxCI,
  input  logic                      RstxRI,
  input  logic                      SliceValidxSI,
  output logic                      SliceReadyxSO,
  input  logic [SHARES*SLICE_W-1:0] SlicexDI,
`ifdef KECCAK_ROW_SEQ_IOTA_EN
  input  logic                      IotaRCxDI,
`endif
  input  logic                      RandValidxSI,
  output logic                      RandReadyxSO,
  input  logic [RAND_W*ROW_W-1:0]   RandxDI,
  output logic [SHARES*ROW_W-1:0]   SboxInxDO,
  output logic [RAND_W*ROW_W-1:0]   SboxZxDO,
  input  logic [SHARES*ROW_W-1:0]   SboxOutxDI,
  output logic                      OutValidxSO,
  input  logic                      OutReadyxSI,
  output logic [SHARES*SLICE_W-1:0] SlicexDO
);

  seq_state_e r_state, w_state_nxt;

  logic [SHARES*SLICE_W-1:0] r_slice;
  logic [SHARES*SLICE_W-1:0] r_out;
  logic [SHARES*SLICE_W-1:0] w_out_nxt;
  logic [2:0]                r_y;
  logic                      w_issue;
  logic                      w_take;
  logic                      w_rc;

  // Capture tracker: one {issued, row} entry per S-box pipeline stage.
  logic [SBOX_LAT-1:0]       r_pipe_vld;
  logic [SBOX_LAT-1:0][2:0]  r_pipe_y;
  logic                      w_tail_vld;
  logic [2:0]                w_tail_y;
  logic                      w_pipe_rest;
  logic [ROW_W-1:0]          w_cap_row;

  always_comb begin
    w_state_nxt   = r_state;
    w_issue       = 1'b0;
    SliceReadyxSO = 1'b0;
    OutValidxSO   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        SliceReadyxSO = !RstxRI;
        if (SliceValidxSI) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_issue = RandValidxSI;
        if (RandValidxSI && r_y == 3'd4) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The tail entry is captured this cycle; done once nothing is behind it.
        if (!w_pipe_rest) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        OutValidxSO = 1'b1;
        if (OutReadyxSI) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_take       = (r_state == ST_IDLE) && SliceValidxSI;
  assign RandReadyxSO = w_issue;
  assign SboxZxDO     = w_issue ? RandxDI : '0;
  assign SlicexDO     = r_out;

  keccak_row_mux #(
    .SHARES (SHARES)
  ) u_row_mux (
    .SlicexDI (r_slice),
    .RowxDI   (r_y),
    .EnxSI    (w_issue),
    .RowxDO   (SboxInxDO)
  );

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      r_state <= ST_IDLE;
      r_slice <= '0;
      r_out   <= '0;
      r_y     <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      if (w_take) begin
        r_slice <= SlicexDI;
        r_y     <= 3'd0;
      end else if (w_issue) begin
        r_y     <= r_y + 3'd1;
      end
    end
  end

`ifdef KECCAK_ROW_SEQ_IOTA_EN
  logic r_rc;

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      r_rc <= 1'b0;
    end else if (w_take) begin
      r_rc <= IotaRCxDI;
    end
  end

  assign w_rc = r_rc;
`else
  assign w_rc = 1'b0;
`endif

  if (SBOX_LAT == 1) begin : g_pipe_single
    always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
        r_pipe_vld <= '0;
        r_pipe_y   <= '0;
      end else begin
        r_pipe_vld[0] <= w_issue;
        r_pipe_y[0]   <= r_y;
      end
    end
    assign w_pipe_rest = 1'b0;
  end else begin : g_pipe_multi
    always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
        r_pipe_vld <= '0;
        r_pipe_y   <= '0;
      end else begin
        r_pipe_vld <= {r_pipe_vld[SBOX_LAT-2:0], w_issue};
        r_pipe_y   <= {r_pipe_y[SBOX_LAT-2:0], r_y};
      end
    end
    assign w_pipe_rest = |r_pipe_vld[SBOX_LAT-2:0];
  end

  assign w_tail_vld = r_pipe_vld[SBOX_LAT-1];
  assign w_tail_y   = r_pipe_y[SBOX_LAT-1];

  for (genvar gy = 0; gy < ROW_W; gy++) begin : g_cap_sel
    assign w_cap_row[gy] = w_tail_vld && (w_tail_y == 3'(gy));
  end

  // Shares stay separate; only share 0, row 0, lane 0 receives the round constant.
  for (genvar gs = 0; gs < SHARES; gs++) begin : g_cap_share
    for (genvar gy = 0; gy < ROW_W; gy++) begin : g_cap_row
      for (genvar gx = 0; gx < ROW_W; gx++) begin : g_cap_lane
        localparam int c_idx  = slice_idx(gs, gy, gx);
        localparam bit c_iota = (gs == 0) && (gy == 0) && (gx == 0);
        assign w_out_nxt[c_idx] = w_cap_row[gy] ?
                                  (SboxOutxDI[gs*ROW_W+gx] ^ (c_iota & w_rc)) :
                                  r_out[c_idx];
      end
    end
  end

endmodule
`default_nettype wire
